crypto_arbiter: RTL and testbench

CRYPTO_ARBITER -- requirements
Module: crypto_arbiter

---
 rtl/crypto_arbiter.sv | 152 +++++++++++++++
 tb/tb_crypto_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_arbiter.sv
// Round-robin arbiter that hands two requesters' crypto operations to a single
// engine, sequencing the engine's reset/start handshake and reporting results.
module crypto_arbiter #(
    parameter int BGN_CYCLES = 10,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [15:0] key0,
    input  logic [15:0] key1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [15:0] res_key,
    output logic [15:0] res_data,
    output logic        busy,
    output logic        eng_rst,
    output logic        eng_bgn,
    output logic [1:0]  eng_mode,
    output logic [15:0] eng_key,
    output logic [15:0] eng_data,
    input  logic        eng_fin,
    input  logic [15:0] eng_key_out,
    input  logic [15:0] eng_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        ENG_RST,
        START,
        WAIT,
        DONE,
        ERR
    } state_t;

    localparam logic [8:0] RST_LAST = 9'(RST_CYCLES - 1);
    localparam logic [8:0] BGN_LAST = 9'(BGN_CYCLES - 1);
    localparam logic [8:0] TO_LAST  = 9'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  cnt;
    logic [8:0]  cnt_nxt;
    logic        last_grant;
    logic        grant;
    logic        grant_sel;
    logic [1:0]  sel_op;
    logic        op_legal;
    logic        fin_take;

    // last_grant doubles as the owner of the operation in flight.
    always_comb begin
        grant     = 1'b0;
        grant_sel = 1'b0;
        if (state == IDLE) begin
            if (req0 && req1) begin
                grant     = 1'b1;
                grant_sel = ~last_grant;
            end else if (req0) begin
                grant     = 1'b1;
                grant_sel = 1'b0;
            end else if (req1) begin
                grant     = 1'b1;
                grant_sel = 1'b1;
            end
        end
    end

    assign sel_op   = grant_sel ? op1 : op0;
    assign op_legal = (sel_op == 2'b01) || (sel_op == 2'b10);
    assign fin_take = eng_fin && ((state == START) || (state == WAIT));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) state_nxt = op_legal ? ENG_RST : ERR;
            end
            ENG_RST: begin
                if (cnt == RST_LAST) state_nxt = START;
            end
            START: begin
                if (eng_fin)              state_nxt = DONE;
                else if (cnt == BGN_LAST) state_nxt = WAIT;
            end
            WAIT: begin
                if (eng_fin)             state_nxt = DONE;
                else if (cnt == TO_LAST) state_nxt = ERR;
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One counter serves every timed state; it restarts on each state change.
    always_comb begin
        if ((state_nxt != state) || (state == IDLE)) cnt_nxt = '0;
        else                                         cnt_nxt = cnt + 9'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            eng_rst    <= 1'b0;
            eng_mode   <= 2'b00;
            eng_key    <= '0;
            eng_data   <= '0;
            res_key    <= '0;
            res_data   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ack0    <= grant && !grant_sel;
            ack1    <= grant && grant_sel;
            eng_rst <= (state_nxt != ENG_RST);
            if (grant) begin
                last_grant <= grant_sel;
                eng_mode   <= sel_op;
                eng_key    <= grant_sel ? key1  : key0;
                eng_data   <= grant_sel ? data1 : data0;
            end
            if (fin_take) begin
                res_key  <= eng_key_out;
                res_data <= eng_data_out;
            end else if (state_nxt == ERR) begin
                res_key  <= '0;
                res_data <= '0;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign eng_bgn = (state == START);
    assign err     = (state == ERR);
    assign done0   = ((state == DONE) || (state == ERR)) && !last_grant;
    assign done1   = ((state == DONE) || (state == ERR)) && last_grant;

endmodule

// File: tb/tb_crypto_arbiter.sv
// Directed bench for crypto_arbiter with a small behavioural engine that
// returns a fixed result a programmable number of cycles into START or WAIT.
module tb_crypto_arbiter;

    localparam int TIMEOUT = 255;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [15:0] key0, key1, data0, data1;
    logic        ack0, ack1, done0, done1, err;
    logic [15:0] res_key, res_data;
    logic        busy, eng_rst, eng_bgn;
    logic [1:0]  eng_mode;
    logic [15:0] eng_key, eng_data;
    logic        eng_fin;
    logic [15:0] eng_key_out, eng_data_out;

    crypto_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .key0(key0), .key1(key1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .err(err),
        .res_key(res_key), .res_data(res_data), .busy(busy),
        .eng_rst(eng_rst), .eng_bgn(eng_bgn), .eng_mode(eng_mode),
        .eng_key(eng_key), .eng_data(eng_data), .eng_fin(eng_fin),
        .eng_key_out(eng_key_out), .eng_data_out(eng_data_out)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // engine model controls
    int   fin_at = 0;      // fire in the Nth cycle after eng_bgn falls (0 = never)
    int   fin_bgn = 0;     // fire in the Nth cycle of eng_bgn high (0 = never)
    logic fin_in_rst = 0;  // fire whenever eng_rst is low
    logic stray_fin = 0;   // fire unconditionally

    // per-operation observations
    logic        drop_req = 1;
    logic        got_done;
    int          ack_cnt, ack_who, ack_cyc, done_who, done_cyc, fall_cyc;
    int          rst_low, bgn_high;
    logic        done_err;
    logic [15:0] rk, rd;
    logic [33:0] eng_at_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Engine model: updates eng_fin on the falling edge so the DUT sees it on the next rise.
    initial begin : engine
        int   lowc;
        int   highc;
        logic armed;
        lowc = 0; highc = 0; armed = 0;
        eng_fin = 1'b0;
        forever begin
            @(negedge clk);
            eng_fin = 1'b0;
            if (rst || !busy) begin
                armed = 0; lowc = 0; highc = 0;
            end else if (eng_bgn) begin
                armed = 1; lowc = 0; highc++;
                if (fin_bgn != 0 && highc == fin_bgn) begin
                    eng_fin = 1'b1; armed = 0;
                end
            end else begin
                highc = 0;
                if (armed) begin
                    lowc++;
                    if (fin_at != 0 && lowc == fin_at) begin
                        eng_fin = 1'b1; armed = 0;
                    end
                end
            end
            if (!rst && fin_in_rst && !eng_rst) eng_fin = 1'b1;
            if (stray_fin) eng_fin = 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input int budget);
        logic prev_bgn;
        got_done = 0; ack_cnt = 0; ack_who = -1; ack_cyc = -1;
        done_who = -1; done_cyc = -1; fall_cyc = -1;
        rst_low = 0; bgn_high = 0; prev_bgn = 0;
        done_err = 0; rk = '0; rd = '0; eng_at_done = '0;
        for (int i = 0; i < budget && !got_done; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                ack_cnt++;
                ack_who = ack1 ? 1 : 0;
                ack_cyc = cyc;
                if (drop_req) begin
                    if (ack0) req0 = 1'b0;
                    if (ack1) req1 = 1'b0;
                end
            end
            if (!eng_rst) rst_low++;
            if (eng_bgn) bgn_high++;
            if (prev_bgn && !eng_bgn && fall_cyc < 0) fall_cyc = cyc;
            prev_bgn = eng_bgn;
            if (done0 || done1) begin
                got_done    = 1;
                done_who    = done1 ? 1 : 0;
                done_cyc    = cyc;
                done_err    = err;
                rk          = res_key;
                rd          = res_data;
                eng_at_done = {eng_mode, eng_key, eng_data};
            end
        end
        check_eq("done_seen", {33'd0, got_done}, 34'd1);
    endtask

    initial begin : main
        int   seq;
        int   cnt_done;
        int   cnt_busy;
        int   low_seen;
        rst = 1'b1;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0;
        key0 = 0; key1 = 0; data0 = 0; data1 = 0;
        eng_key_out = 0; eng_data_out = 0;

        // reset values
        repeat (2) @(negedge clk);
        check_eq("rst_ctrl", {ack0, ack1, done0, done1, err, busy, eng_rst, eng_bgn, eng_mode},
                 34'd0);
        check_eq("rst_eng", {eng_key, eng_data}, 34'd0);
        check_eq("rst_res", {res_key, res_data}, 34'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_release_eng_rst", {33'd0, eng_rst}, 34'd1);
        check_eq("rst_release_busy", {33'd0, busy}, 34'd0);

        // encrypt, engine answers in the 20th cycle after eng_bgn falls
        req0 = 1; op0 = 2'b01; key0 = 16'h1325; data0 = 16'h59B3;
        eng_key_out = 16'hA1B2; eng_data_out = 16'hC3D4;
        fin_at = 20; drop_req = 1;
        run_op(100);
        check_eq("enc_ack_who", ack_who, 0);
        check_eq("enc_ack_cnt", ack_cnt, 1);
        check_eq("enc_rst_low", rst_low, 2);
        check_eq("enc_bgn_high", bgn_high, 10);
        check_eq("enc_latency", done_cyc - ack_cyc, 32);
        check_eq("enc_done_who", done_who, 0);
        check_eq("enc_err", {33'd0, done_err}, 34'd0);
        check_eq("enc_res", {rk, rd}, {2'b00, 16'hA1B2, 16'hC3D4});
        check_eq("enc_eng_hold", eng_at_done, {2'b01, 16'h1325, 16'h59B3});
        @(negedge clk);
        check_eq("enc_after", {busy, done0, done1}, 34'd0);
        check_eq("enc_res_hold", {res_key, res_data}, {2'b00, 16'hA1B2, 16'hC3D4});

        // tie straight from reset: requester 0 then requester 1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1; req1 = 1; op0 = 2'b01; op1 = 2'b10;
        key1 = 16'hBEEF; data1 = 16'hCAFE;
        fin_at = 3;
        run_op(60);
        check_eq("tie_first_ack", ack_who, 0);
        check_eq("tie_first_ack_cnt", ack_cnt, 1);
        check_eq("tie_first_done", done_who, 0);
        run_op(60);
        check_eq("tie_second_ack", ack_who, 1);
        check_eq("tie_second_done", done_who, 1);
        check_eq("tie_second_mode", eng_at_done, {2'b10, 16'hBEEF, 16'hCAFE});

        // continuous requests alternate
        req0 = 1; req1 = 1; drop_req = 0; seq = 0;
        for (int k = 0; k < 4; k++) begin
            run_op(60);
            seq = (seq << 1) | ack_who;
            check_eq("alt_ack_cnt", ack_cnt, 1);
        end
        req0 = 0; req1 = 0; drop_req = 1;
        check_eq("alt_order", seq, 4'b0101);

        // illegal op: error reported immediately, engine never started
        req1 = 1; op1 = 2'b11;
        run_op(10);
        check_eq("ill_ack_who", ack_who, 1);
        check_eq("ill_done_who", done_who, 1);
        check_eq("ill_err", {33'd0, done_err}, 34'd1);
        check_eq("ill_res", {rk, rd}, 34'd0);
        check_eq("ill_latency", done_cyc - ack_cyc, 0);
        check_eq("ill_bgn", bgn_high, 0);
        @(negedge clk);
        check_eq("ill_after_busy", {33'd0, busy}, 34'd0);

        // timeout: engine silent
        req0 = 1; op0 = 2'b10; fin_at = 0;
        run_op(400);
        check_eq("to_done_who", done_who, 0);
        check_eq("to_err", {33'd0, done_err}, 34'd1);
        check_eq("to_latency", done_cyc - fall_cyc, TIMEOUT);
        check_eq("to_mode", {32'd0, eng_at_done[33:32]}, 34'd2);
        @(negedge clk);
        check_eq("to_after_busy", {33'd0, busy}, 34'd0);

        // stray fin while idle is ignored
        stray_fin = 1;
        cnt_done = 0; cnt_busy = 0;
        repeat (3) @(negedge clk);
        stray_fin = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0 || done1) cnt_done++;
            if (busy) cnt_busy++;
        end
        check_eq("stray_idle", cnt_done + cnt_busy, 0);

        // fin during START ends early; fin while eng_rst is low is ignored
        req0 = 1; op0 = 2'b01; fin_at = 0; fin_bgn = 5; fin_in_rst = 1;
        eng_key_out = 16'h5A5A; eng_data_out = 16'hA5A5;
        run_op(60);
        fin_bgn = 0; fin_in_rst = 0;
        check_eq("early_bgn_high", bgn_high, 5);
        check_eq("early_latency", done_cyc - ack_cyc, 7);
        check_eq("early_err", {33'd0, done_err}, 34'd0);
        check_eq("early_res", {rk, rd}, {2'b00, 16'h5A5A, 16'hA5A5});

        // reset in WAIT abandons the operation
        req0 = 1; op0 = 2'b01; fin_at = 0; low_seen = 0;
        for (int i = 0; i < 40 && low_seen < 5; i++) begin
            @(negedge clk);
            if (ack0) req0 = 0;
            if (busy && !eng_bgn && eng_rst && !ack0) low_seen++;
        end
        check_eq("wrst_reached_wait", low_seen, 5);
        #2 rst = 1'b1;
        #1;
        check_eq("wrst_ctrl", {ack0, ack1, done0, done1, err, busy, eng_rst, eng_bgn, eng_mode},
                 34'd0);
        check_eq("wrst_eng", {eng_key, eng_data}, 34'd0);
        check_eq("wrst_res", {res_key, res_data}, 34'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done0 || done1 || busy) cnt_done++;
        end
        check_eq("wrst_quiet", cnt_done, 0);

        req1 = 1; op1 = 2'b01; key1 = 16'h0F0F; data1 = 16'hF0F0;
        fin_at = 2; eng_key_out = 16'h1111; eng_data_out = 16'h2222;
        run_op(60);
        check_eq("post_ack_who", ack_who, 1);
        check_eq("post_done_who", done_who, 1);
        check_eq("post_err", {33'd0, done_err}, 34'd0);
        check_eq("post_latency", done_cyc - ack_cyc, 14);
        check_eq("post_res", {rk, rd}, {2'b00, 16'h1111, 16'h2222});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
